// File: rtl/pmod_led_sequencer.sv
// Mode-selectable LED pattern sequencer for an 8-LED PMOD bar (active-low drive).
// Optional PWM dimming is compiled in with macro LED_PWM_EN.
module pmod_led_sequencer #(
    parameter int PRESCALE = 1048576,
    parameter int DUTY     = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       MODE_REQ,
    output logic [7:0] LED_N,
    output logic [1:0] MODE,
    output logic       STEP_TICK
);
    // state  | meaning
    // BOUNCE | single lit LED sweeping up and down the bar
    // FILL   | Johnson fill/drain, period 16
    // BLINK  | alternating 0x55 / 0xAA
    // COUNT  | 8-bit binary count
    typedef enum logic [1:0] {BOUNCE = 2'd0, FILL = 2'd1, BLINK = 2'd2, COUNT = 2'd3} mode_t;

    localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] TOP = CW'(PRESCALE - 1);

    if (PRESCALE < 2 || PRESCALE > 16777216) begin : g_bad_prescale
        $error("PRESCALE out of range 2..2^24");
    end
    if (DUTY < 1 || DUTY > 16) begin : g_bad_duty
        $error("DUTY out of range 1..16");
    end

    mode_t         mode_q, mode_d;
    logic [7:0]    pat_q, pat_d;
    logic          up_q, up_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          req_q;
    logic          tick_q;
    logic          wrap;
    logic          req_edge;
    logic [7:0]    lit;

    assign wrap     = EN && (cnt_q == TOP);
    assign req_edge = MODE_REQ && !req_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_q <= BOUNCE;
            pat_q  <= 8'h01;
            up_q   <= 1'b1;
            cnt_q  <= '0;
            pend_q <= 1'b0;
            req_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            pat_q  <= pat_d;
            up_q   <= up_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            req_q  <= MODE_REQ;
            tick_q <= wrap;
        end
    end

    always_comb begin
        mode_d = mode_q;
        pat_d  = pat_q;
        up_d   = up_q;
        cnt_d  = cnt_q;
        pend_d = pend_q || req_edge;
        if (EN) begin
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
        end
        if (wrap) begin
            if (pend_q || req_edge) begin
                // a request replaces the step with the next mode's start pattern
                pend_d = 1'b0;
                mode_d = mode_t'(mode_q + 2'd1);
                case (mode_d)
                    BOUNCE: begin
                        pat_d = 8'h01;
                        up_d  = 1'b1;
                    end
                    FILL:    pat_d = 8'h00;
                    BLINK:   pat_d = 8'h55;
                    default: pat_d = 8'h00;
                endcase
            end else begin
                case (mode_q)
                    BOUNCE: begin
                        if (up_q) begin
                            if (pat_q == 8'h80) begin
                                pat_d = 8'h40;
                                up_d  = 1'b0;
                            end else begin
                                pat_d = {pat_q[6:0], 1'b0};
                            end
                        end else begin
                            if (pat_q == 8'h01) begin
                                pat_d = 8'h02;
                                up_d  = 1'b1;
                            end else begin
                                pat_d = {1'b0, pat_q[7:1]};
                            end
                        end
                    end
                    FILL:    pat_d = {pat_q[6:0], ~pat_q[7]};
                    BLINK:   pat_d = ~pat_q;
                    default: pat_d = pat_q + 8'd1;
                endcase
            end
        end
    end

`ifdef LED_PWM_EN
    localparam logic [4:0] DUTY_W = 5'(DUTY);
    logic [3:0] pwm_q;

    // free-running so brightness is independent of EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) pwm_q <= 4'd0;
        else     pwm_q <= pwm_q + 4'd1;
    end

    assign lit = ({1'b0, pwm_q} < DUTY_W) ? pat_q : 8'h00;
`else
    assign lit = pat_q;
`endif

    assign LED_N     = ~lit;
    assign MODE      = mode_q;
    assign STEP_TICK = tick_q;

endmodule

// File: tb/tb_pmod_led_sequencer.sv
// Directed bench for pmod_led_sequencer with PRESCALE=4, DUTY=4.
// Default build runs the sequencing scenarios; LED_PWM_EN runs the dimming scenario.
module tb_pmod_led_sequencer;
    logic       CLK;
    logic       RST;
    logic       EN;
    logic       MODE_REQ;
    logic [7:0] LED_N;
    logic [1:0] MODE;
    logic       STEP_TICK;

    int total = 0;
    int bad   = 0;

    pmod_led_sequencer #(.PRESCALE(4), .DUTY(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (EN),
        .MODE_REQ (MODE_REQ),
        .LED_N    (LED_N),
        .MODE     (MODE),
        .STEP_TICK(STEP_TICK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // returns cycles until the next STEP_TICK seen at a falling edge, bounded
    task automatic wait_step(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            cyc++;
            if (STEP_TICK === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        RST = 1'b1; EN = 1'b1; MODE_REQ = 1'b0;
        repeat (3) @(negedge CLK);
        total++;
        if (LED_N !== 8'hFE || MODE !== 2'd0 || STEP_TICK !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: led_n=%h mode=%0d tick=%b want fe 0 0", LED_N, MODE, STEP_TICK);
        end
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            total++;
            if (STEP_TICK !== 1'b0) begin
                bad++;
                $display("FAIL early_tick: cycle %0d tick=%b want 0", i + 1, STEP_TICK);
            end
        end
        @(negedge CLK);
        total++;
        if (STEP_TICK !== 1'b1 || LED_N !== 8'hFD || MODE !== 2'd0) begin
            bad++;
            $display("FAIL first_step: tick=%b led_n=%h mode=%0d want 1 fd 0", STEP_TICK, LED_N, MODE);
        end
    endtask

    task automatic test_bounce;
        logic [7:0] bval [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        int cyc;
        bit ok;
        for (int i = 2; i < 16; i++) begin
            wait_step(cyc, ok);
            total++;
            if (!ok || cyc != 4) begin
                bad++;
                $display("FAIL bounce_spacing: step %0d ok=%b cycles=%0d want 4", i, ok, cyc);
            end
            total++;
            if (LED_N !== ~bval[i] || MODE !== 2'd0) begin
                bad++;
                $display("FAIL bounce_pattern: step %0d led_n=%h mode=%0d want %h 0", i, LED_N, MODE, ~bval[i]);
            end
        end
    endtask

    task automatic test_mode_collapse;
        logic [7:0] fexp [3] = '{8'hFF, 8'hFE, 8'hFC};
        int cyc;
        bit ok;
        EN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            MODE_REQ = 1'b1;
            @(negedge CLK);
            MODE_REQ = 1'b0;
            @(negedge CLK);
        end
        EN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_step(cyc, ok);
            total++;
            if (!ok || cyc != 4 || MODE !== 2'd1 || LED_N !== fexp[i]) begin
                bad++;
                $display("FAIL collapse_fill: step %0d ok=%b cycles=%0d mode=%0d led_n=%h want 4 1 %h",
                         i, ok, cyc, MODE, LED_N, fexp[i]);
            end
        end
    endtask

    task automatic test_edge_at_wrap;
        logic [7:0] want;
        int cyc;
        bit ok;
        repeat (3) @(negedge CLK);
        MODE_REQ = 1'b1;
        @(negedge CLK);
        total++;
        if (STEP_TICK !== 1'b1 || MODE !== 2'd2 || LED_N !== 8'hAA) begin
            bad++;
            $display("FAIL wrap_req_blink: tick=%b mode=%0d led_n=%h want 1 2 aa", STEP_TICK, MODE, LED_N);
        end
        MODE_REQ = 1'b0;
        wait_step(cyc, ok);
        total++;
        if (!ok || cyc != 4 || LED_N !== 8'h55) begin
            bad++;
            $display("FAIL blink_toggle: ok=%b cycles=%0d led_n=%h want 4 55", ok, cyc, LED_N);
        end
        repeat (3) @(negedge CLK);
        MODE_REQ = 1'b1;
        @(negedge CLK);
        total++;
        if (STEP_TICK !== 1'b1 || MODE !== 2'd3 || LED_N !== 8'hFF) begin
            bad++;
            $display("FAIL wrap_req_count: tick=%b mode=%0d led_n=%h want 1 3 ff", STEP_TICK, MODE, LED_N);
        end
        MODE_REQ = 1'b0;
        for (int k = 1; k <= 256; k++) begin
            want = 8'(k);
            wait_step(cyc, ok);
            total++;
            if (!ok || cyc != 4 || LED_N !== ~want || MODE !== 2'd3) begin
                bad++;
                $display("FAIL count_step: step %0d ok=%b cycles=%0d led_n=%h mode=%0d want 4 %h 3",
                         k, ok, cyc, LED_N, MODE, ~want);
            end
        end
    endtask

    task automatic test_en_freeze;
        int cyc;
        bit ok;
        repeat (2) @(negedge CLK);
        EN = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) MODE_REQ = 1'b1;
            if (i == 7) MODE_REQ = 1'b0;
            @(negedge CLK);
            total++;
            if (STEP_TICK !== 1'b0 || LED_N !== 8'hFF || MODE !== 2'd3) begin
                bad++;
                $display("FAIL freeze: cycle %0d tick=%b led_n=%h mode=%0d want 0 ff 3", i, STEP_TICK, LED_N, MODE);
            end
        end
        EN = 1'b1;
        wait_step(cyc, ok);
        total++;
        if (!ok || cyc != 2 || MODE !== 2'd0 || LED_N !== 8'hFE) begin
            bad++;
            $display("FAIL resume_advance: ok=%b cycles=%0d mode=%0d led_n=%h want 2 0 fe", ok, cyc, MODE, LED_N);
        end
        wait_step(cyc, ok);
        total++;
        if (!ok || cyc != 4 || LED_N !== 8'hFD) begin
            bad++;
            $display("FAIL resume_bounce: ok=%b cycles=%0d led_n=%h want 4 fd", ok, cyc, LED_N);
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        bit ok;
        @(negedge CLK);
        MODE_REQ = 1'b1;
        @(negedge CLK);
        MODE_REQ = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        #1;
        total++;
        if (LED_N !== 8'hFE || MODE !== 2'd0 || STEP_TICK !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: led_n=%h mode=%0d tick=%b want fe 0 0", LED_N, MODE, STEP_TICK);
        end
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        wait_step(cyc, ok);
        total++;
        if (!ok || cyc != 4 || MODE !== 2'd0 || LED_N !== 8'hFD) begin
            bad++;
            $display("FAIL pending_dropped: ok=%b cycles=%0d mode=%0d led_n=%h want 4 0 fd", ok, cyc, MODE, LED_N);
        end
    endtask

    task automatic test_pwm;
        int on_cnt;
        int cyc;
        bit ok;
        RST = 1'b1; EN = 1'b0; MODE_REQ = 1'b0;
        repeat (2) @(negedge CLK);
        total++;
        if (LED_N !== 8'hFE) begin
            bad++;
            $display("FAIL pwm_reset: led_n=%h want fe", LED_N);
        end
        RST = 1'b0;
        on_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge CLK);
            if (LED_N[0] === 1'b0) on_cnt++;
            total++;
            if (LED_N[7:1] !== 7'h7F) begin
                bad++;
                $display("FAIL pwm_dark_bits: cycle %0d led_n=%h want upper bits 1", i, LED_N);
            end
        end
        total++;
        if (on_cnt != 8) begin
            bad++;
            $display("FAIL pwm_duty: on cycles=%0d of 32 want 8", on_cnt);
        end
        MODE_REQ = 1'b1;
        @(negedge CLK);
        MODE_REQ = 1'b0;
        EN = 1'b1;
        wait_step(cyc, ok);
        total++;
        if (!ok || MODE !== 2'd1) begin
            bad++;
            $display("FAIL pwm_mode_adv: ok=%b mode=%0d want 1", ok, MODE);
        end
        RST = 1'b1;
        #1;
        total++;
        if (LED_N !== 8'hFE || MODE !== 2'd0) begin
            bad++;
            $display("FAIL pwm_mid_reset: led_n=%h mode=%0d want fe 0", LED_N, MODE);
        end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1; EN = 1'b0; MODE_REQ = 1'b0;
`ifdef LED_PWM_EN
        test_pwm;
`else
        test_reset;
        test_bounce;
        test_mode_collapse;
        test_edge_at_wrap;
        test_en_freeze;
        test_reset_mid;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
